// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler: one decoder-driven resource shared by NREQ
// requesters. Grants are registered and one-hot, and gnt_idx feeds the
// decoder select. An owner keeps the grant until it asserts done, drops its
// request, or runs into the optional hold limit.
module rr_grant_scheduler #(
    parameter int NREQ     = 8,
    parameter int IDXW     = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // MAX_HOLD == 0 turns the limit off. The guard keeps MAX_HOLD-1 from
    // wrapping in that case.
    localparam bit              HOLD_EN  = (MAX_HOLD != 0);
    localparam logic [15:0]     HOLD_LIM = HOLD_EN ? 16'(MAX_HOLD - 1) : 16'd0;
    localparam logic [NREQ-1:0] ONE      = NREQ'(1);

    state_t          state;
    logic [15:0]     hold_cnt;
    logic [IDXW-1:0] last_idx;

    logic            found;
    logic [IDXW-1:0] sel;
    logic            limit_hit;
    logic            owner_req;
    logic            release_now;

    // Rotating search. It starts just past the last owner, and IDXW-bit
    // wraparound provides the modulo NREQ. The last owner is checked last.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req[last_idx + IDXW'(k)]) begin
                found = 1'b1;
                sel   = last_idx + IDXW'(k);
            end
        end
    end

    // Release conditions for the current owner. These are used only in GRANT.
    always_comb begin
        owner_req   = req[gnt_idx];
        limit_hit   = HOLD_EN && (hold_cnt == HOLD_LIM);
        release_now = done || !owner_req || limit_hit;
    end

    // Scheduler FSM. All outputs are registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            last_idx  <= IDXW'(NREQ - 1);
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt       <= ONE << sel;
                        gnt_idx   <= sel;
                        gnt_valid <= 1'b1;
                        last_idx  <= sel;
                        hold_cnt  <= '0;
                        state     <= GRANT;
                    end else begin
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                    end
                end
                GRANT: begin
                    if (hold_cnt != 16'hFFFF)
                        hold_cnt <= hold_cnt + 16'd1;
                    if (release_now) begin
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        // Flag a revocation only when the limit alone ends the grant.
                        timeout   <= limit_hit && !done && owner_req;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Self-checking bench for rr_grant_scheduler, built with MAX_HOLD=4.
module tb_rr_grant_scheduler;

    localparam int NREQ     = 8;
    localparam int IDXW     = 3;
    localparam int MAX_HOLD = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic            done = 1'b0;
    logic [NREQ-1:0] gnt;
    logic [IDXW-1:0] gnt_idx;
    logic            gnt_valid;
    logic            timeout;

    int n_chk  = 0;
    int n_fail = 0;

    rr_grant_scheduler #(.NREQ(NREQ), .IDXW(IDXW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Reference model. It tracks the owner, the edges that owner has held,
    // and the number of quiet edges still owed before arbitration resumes.
    int m_owner, m_last, m_idx, m_held, m_wait;
    bit m_to;

    function automatic void model_reset();
        m_owner = -1; m_last = NREQ - 1; m_idx = 0; m_held = 0; m_wait = 0; m_to = 0;
    endfunction

    function automatic void model_step(input logic [NREQ-1:0] r, input logic d);
        m_to = 0;
        if (m_owner >= 0) begin
            bit hit;
            m_held++;
            hit = (MAX_HOLD != 0) && (m_held >= MAX_HOLD);
            if (d || !r[m_owner] || hit) begin
                m_to    = hit && !d && r[m_owner];
                m_owner = -1;
                m_wait  = 1;
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                int i;
                i = (m_last + k) % NREQ;
                if (m_owner < 0 && r[i]) begin
                    m_owner = i; m_last = i; m_idx = i; m_held = 0;
                end
            end
        end
    endfunction

    function automatic logic [31:0] model_out();
        logic [NREQ-1:0] g;
        g = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
        return {19'd0, g, IDXW'(m_idx), (m_owner >= 0), m_to};
    endfunction

    function automatic logic [31:0] dut_out();
        return {19'd0, gnt, gnt_idx, gnt_valid, timeout};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (gnt,idx,valid,timeout packed)", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, step the model at the edge, then sample
    // just after the edge.
    task automatic tick(input logic [NREQ-1:0] r, input logic d, input bit cmp, input string name);
        req = r; done = d;
        @(posedge clk);
        model_step(r, d);
        #1;
        if (cmp) chk(name, dut_out(), model_out());
    endtask

    task automatic do_reset();
        req = '0; done = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        chk("reset_state", dut_out(), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic [NREQ-1:0] req;
        logic            done;
        logic [NREQ-1:0] gnt;
        logic [IDXW-1:0] idx;
        logic            vld;
        logic            to;
    } vec_t;

    vec_t tbl[23];

    initial begin
        // Vectors start from reset. Columns: req, done -> gnt, idx, valid, timeout.
        tbl[0]  = '{8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0}; // first grant to 0
        tbl[1]  = '{8'h01, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0}; // done release
        tbl[2]  = '{8'h08, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0}; // GAP
        tbl[3]  = '{8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0}; // grant 3
        tbl[4]  = '{8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[5]  = '{8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[6]  = '{8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0}; // 4th held cycle
        tbl[7]  = '{8'h08, 1'b0, 8'h00, 3'd3, 1'b0, 1'b1}; // timeout pulse
        tbl[8]  = '{8'h08, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0}; // IDLE
        tbl[9]  = '{8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0}; // lone regrant
        tbl[10] = '{8'h20, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0}; // owner drops req
        tbl[11] = '{8'h20, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0};
        tbl[12] = '{8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0}; // grant 5
        tbl[13] = '{8'h20, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0};
        tbl[14] = '{8'h00, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0}; // done in GAP
        tbl[15] = '{8'h00, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0}; // done in IDLE
        tbl[16] = '{8'h00, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0};
        tbl[17] = '{8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0}; // search wraps past 7 to 2
        tbl[18] = '{8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0};
        tbl[19] = '{8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0};
        tbl[20] = '{8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0};
        tbl[21] = '{8'h04, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0}; // done + limit: no timeout
        tbl[22] = '{8'h00, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0};

        // Table-driven directed vectors.
        do_reset();
        for (int v = 0; v < 23; v++) begin
            tick(tbl[v].req, tbl[v].done, 1'b0, "");
            chk($sformatf("vec%0d", v), dut_out(),
                {19'd0, tbl[v].gnt, tbl[v].idx, tbl[v].vld, tbl[v].to});
        end

        // Full request set, done one cycle after each grant: sequence 0..7,0.
        do_reset();
        tick(8'hFF, 1'b0, 1'b0, "");
        chk("rr_grant0", dut_out(), {19'd0, 8'h01, 3'd0, 1'b1, 1'b0});
        for (int n = 1; n <= 8; n++) begin
            tick(8'hFF, 1'b1, 1'b0, "");
            chk($sformatf("rr_gap_a%0d", n), {24'd0, gnt}, 32'd0);
            tick(8'hFF, 1'b0, 1'b0, "");
            chk($sformatf("rr_gap_b%0d", n), {24'd0, gnt}, 32'd0);
            tick(8'hFF, 1'b0, 1'b0, "");
            chk($sformatf("rr_grant%0d", n), dut_out(),
                {19'd0, 8'h01 << (n % 8), 3'(n % 8), 1'b1, 1'b0});
        end

        // Asynchronous reset mid-grant to owner 6.
        do_reset();
        tick(8'h40, 1'b0, 1'b0, "");
        chk("pre_rst_grant6", dut_out(), {19'd0, 8'h40, 3'd6, 1'b1, 1'b0});
        #2 reset = 1'b1;
        #1 chk("async_rst_drop", dut_out(), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        tick(8'hFF, 1'b0, 1'b0, "");
        chk("post_rst_grant0", dut_out(), {19'd0, 8'h01, 3'd0, 1'b1, 1'b0});

        // Randomized traffic checked every cycle against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [NREQ-1:0] r;
            logic            d;
            r = NREQ'($urandom);
            if ($urandom_range(3) == 0) r = '0;
            if ($urandom_range(4) == 0) r = NREQ'(1) << $urandom_range(NREQ - 1);
            d = ($urandom_range(5) == 0);
            tick(r, d, 1'b1, $sformatf("rand_c%0d", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
